// File: rtl/ghost_chase_dir_if.sv
// Request/response bundle for the ghost chase direction chooser.
// Handshake: the requester raises start for one cycle while busy=0; the
// search result (dir, best_dis2, dir_valid, all_blocked) is valid in the
// cycle where done=1. start is ignored while busy=1; stop aborts a search.
interface ghost_chase_dir_if;
    logic        start;
    logic        stop;
    logic [9:0]  ghostX;
    logic [9:0]  ghostY;
    logic [9:0]  pacX;
    logic [9:0]  pacY;
    logic [3:0]  wall_mask;
    logic [1:0]  cur_dir;
    logic [1:0]  dir;
    logic        dir_valid;
    logic        busy;
    logic        done;
    logic        all_blocked;
    logic [22:0] best_dis2;
    logic [2:0]  fsm_state;

    modport master (
        output start, stop, ghostX, ghostY, pacX, pacY, wall_mask, cur_dir,
        input  dir, dir_valid, busy, done, all_blocked, best_dis2, fsm_state
    );

    modport slave (
        input  start, stop, ghostX, ghostY, pacX, pacY, wall_mask, cur_dir,
        output dir, dir_valid, busy, done, all_blocked, best_dis2, fsm_state
    );
endinterface

// File: rtl/ghost_chase_dir.sv
// Sequential ghost direction chooser: scores left/right/up/down probe points
// by squared distance to Pac-Man through one shared multiplier and returns
// the best legal direction in the ghost motion encoding.
module ghost_chase_dir #(
    parameter int STEP       = 8,
    parameter bit CHASE      = 1'b1,
    parameter bit NO_REVERSE = 1'b1
) (
    input logic         Clk,
    input logic         Reset_n,
    ghost_chase_dir_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SQX  = 3'd2,
        SQY  = 3'd3,
        CMP  = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam logic signed [10:0] STEP_S = 11'(STEP);

    state_t state, next_state;

    logic [9:0]         gx, gy, px, py;
    logic [3:0]         mask;
    logic [1:0]         cdir;
    logic [1:0]         k, k_sel;
    logic signed [10:0] cand_x, cand_y, nx, ny;
    logic [21:0]        sq_x, sq_y, product;
    logic [22:0]        best_val, sum;
    logic [1:0]         best_k;
    logic               has_best;

    logic [11:0]        dx, dy;
    logic [10:0]        abs_dx, abs_dy, mult_in;
    logic [1:0]         rev;
    logic [3:0]         open_vec, rev_onehot, excl, legal_vec;
    logic               nonrev_open, cur_legal, better, take;

    assign bus.fsm_state = state;

    // Next-state logic; stop forces any active search back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start && !bus.stop) next_state = LOAD;
            LOAD: next_state = SQX;
            SQX:  next_state = SQY;
            SQY:  next_state = CMP;
            CMP:  next_state = (k == 2'd3) ? FIN : SQX;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (state != IDLE && bus.stop) next_state = IDLE;
    end

    // Probe coordinates for the candidate about to be scored; the other axis
    // keeps the ghost coordinate and negative values are kept as-is.
    always_comb begin
        k_sel = (state == CMP) ? k + 2'd1 : 2'd0;
        nx    = $signed({1'b0, gx});
        ny    = $signed({1'b0, gy});
        case (k_sel)
            2'd0: nx = $signed({1'b0, gx}) - STEP_S;
            2'd1: nx = $signed({1'b0, gx}) + STEP_S;
            2'd2: ny = $signed({1'b0, gy}) - STEP_S;
            default: ny = $signed({1'b0, gy}) + STEP_S;
        endcase
    end

    // Shared squaring datapath: |dx| in SQX, |dy| in SQY.
    always_comb begin
        dx      = {cand_x[10], cand_x} - {2'b00, px};
        dy      = {cand_y[10], cand_y} - {2'b00, py};
        abs_dx  = dx[11] ? 11'(-dx) : dx[10:0];
        abs_dy  = dy[11] ? 11'(-dy) : dy[10:0];
        mult_in = (state == SQX) ? abs_dx : abs_dy;
        product = {11'd0, mult_in} * {11'd0, mult_in};
        sum     = {1'b0, sq_x} + {1'b0, sq_y};
    end

    // Legality and running-best decision for the current candidate. The
    // reverse direction only becomes legal when nothing else is open.
    always_comb begin
        rev         = {cdir[1], ~cdir[0]};
        open_vec    = ~mask;
        rev_onehot  = 4'b0001 << rev;
        nonrev_open = |(open_vec & ~rev_onehot);
        excl        = (NO_REVERSE && nonrev_open) ? rev_onehot : 4'b0000;
        legal_vec   = open_vec & ~excl;
        cur_legal   = legal_vec[k];
        if (CHASE) better = (sum < best_val);
        else       better = (sum > best_val);
        take        = cur_legal && (!has_best || better);
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Search datapath: input capture, probe registers, squares, running best.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gx <= '0; gy <= '0; px <= '0; py <= '0;
            mask <= '0; cdir <= '0; k <= '0;
            cand_x <= '0; cand_y <= '0; sq_x <= '0; sq_y <= '0;
            best_val <= '0; best_k <= '0; has_best <= 1'b0;
        end else begin
            if (state == IDLE && next_state == LOAD) begin
                gx   <= bus.ghostX;
                gy   <= bus.ghostY;
                px   <= bus.pacX;
                py   <= bus.pacY;
                mask <= bus.wall_mask;
                cdir <= bus.cur_dir;
            end
            if (state == LOAD) has_best <= 1'b0;
            if ((state == LOAD || state == CMP) && next_state == SQX) begin
                cand_x <= nx;
                cand_y <= ny;
                k      <= k_sel;
            end
            if (state == SQX) sq_x <= product;
            if (state == SQY) sq_y <= product;
            if (state == CMP && take) begin
                best_val <= sum;
                best_k   <= k;
                has_best <= 1'b1;
            end
        end
    end

    // Registered outputs; results commit on the edge that enters FIN.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.dir         <= 2'b00;
            bus.dir_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.all_blocked <= 1'b0;
            bus.best_dis2   <= '0;
        end else begin
            bus.busy <= (next_state != IDLE);
            bus.done <= (next_state == FIN);
            if (state == CMP && next_state == FIN) begin
                if (take || has_best) begin
                    bus.dir         <= take ? k : best_k;
                    bus.best_dis2   <= take ? sum : best_val;
                    bus.dir_valid   <= 1'b1;
                    bus.all_blocked <= 1'b0;
                end else begin
                    bus.dir_valid   <= 1'b0;
                    bus.all_blocked <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ghost_chase_dir.sv
// Bench for ghost_chase_dir: a chase instance and a flee instance share the
// position inputs; results are checked by negedge monitors against queues.
module tb_ghost_chase_dir;
    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    ghost_chase_dir_if b0();
    ghost_chase_dir_if b1();

    ghost_chase_dir #(.STEP(8), .CHASE(1'b1), .NO_REVERSE(1'b1)) dut_chase (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b0.slave)
    );
    ghost_chase_dir #(.STEP(8), .CHASE(1'b0), .NO_REVERSE(1'b1)) dut_flee (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b1.slave)
    );

    assign b1.ghostX    = b0.ghostX;
    assign b1.ghostY    = b0.ghostY;
    assign b1.pacX      = b0.pacX;
    assign b1.pacY      = b0.pacY;
    assign b1.wall_mask = b0.wall_mask;
    assign b1.cur_dir   = b0.cur_dir;
    assign b1.stop      = 1'b0;

    // expected entry: {dir[1:0], dir_valid, all_blocked, best_dis2[22:0]}
    logic [26:0] exp_q0[$];
    logic [26:0] exp_q1[$];
    int n_vec = 0;
    int n_err = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [26:0] pack(input logic [1:0] d, input logic v,
                                         input logic ab, input logic [22:0] b);
        return {d, v, ab, b};
    endfunction

    // Chase instance monitor.
    always @(negedge Clk) begin
        if (Reset_n && b0.done) begin
            logic [26:0] e;
            done_cnt0++;
            if (exp_q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL chase_unexpected_done: got done with empty queue, expected no done");
            end else begin
                e = exp_q0.pop_front();
                check("chase_dir", 32'(b0.dir), 32'(e[26:25]));
                check("chase_dir_valid", 32'(b0.dir_valid), 32'(e[24]));
                check("chase_all_blocked", 32'(b0.all_blocked), 32'(e[23]));
                check("chase_best_dis2", 32'(b0.best_dis2), 32'(e[22:0]));
            end
        end
    end

    // Flee instance monitor.
    always @(negedge Clk) begin
        if (Reset_n && b1.done) begin
            logic [26:0] e;
            done_cnt1++;
            if (exp_q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL flee_unexpected_done: got done with empty queue, expected no done");
            end else begin
                e = exp_q1.pop_front();
                check("flee_dir", 32'(b1.dir), 32'(e[26:25]));
                check("flee_dir_valid", 32'(b1.dir_valid), 32'(e[24]));
                check("flee_all_blocked", 32'(b1.all_blocked), 32'(e[23]));
                check("flee_best_dis2", 32'(b1.best_dis2), 32'(e[22:0]));
            end
        end
    end

    task automatic set_inputs(input logic [9:0] gx, input logic [9:0] gy,
                              input logic [9:0] px, input logic [9:0] py,
                              input logic [3:0] m, input logic [1:0] cd);
        b0.ghostX = gx; b0.ghostY = gy; b0.pacX = px; b0.pacY = py;
        b0.wall_mask = m; b0.cur_dir = cd;
    endtask

    // Raise start on one instance for the next edge; returns #1 after it.
    task automatic pulse_start(input int sel);
        if (sel == 0) b0.start = 1'b1; else b1.start = 1'b1;
        @(posedge Clk); #1;
        b0.start = 1'b0; b1.start = 1'b0;
    endtask

    // Full search with latency and pulse-width checks.
    task automatic run(input int sel, input logic [26:0] e);
        int n;
        logic d;
        if (sel == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        pulse_start(sel);
        n = 0;
        d = 1'b0;
        while (!d && n < 40) begin
            @(posedge Clk); #1;
            n++;
            d = (sel == 0) ? b0.done : b1.done;
        end
        check("done_latency", 32'(n), 32'd13);
        @(posedge Clk); #1;
        d = (sel == 0) ? b0.done : b1.done;
        check("done_pulse_width", 32'(d), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dir"}, 32'(b0.dir), 32'd0);
        check({tag, "_dir_valid"}, 32'(b0.dir_valid), 32'd0);
        check({tag, "_busy"}, 32'(b0.busy), 32'd0);
        check({tag, "_done"}, 32'(b0.done), 32'd0);
        check({tag, "_all_blocked"}, 32'(b0.all_blocked), 32'd0);
        check({tag, "_best_dis2"}, 32'(b0.best_dis2), 32'd0);
        check({tag, "_fsm_state"}, 32'(b0.fsm_state), 32'd0);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int base;
        Reset_n = 1'b0;
        b0.start = 1'b0; b0.stop = 1'b0; b1.start = 1'b0;
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b0000, 2'b00);
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Chase: all open, left is closest.
        run(0, pack(2'b00, 1'b1, 1'b0, 23'd121104));
        // Left walled, right is reverse: up/down tie, up wins.
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b0001, 2'b00);
        run(0, pack(2'b10, 1'b1, 1'b0, 23'd126800));
        // Only the reverse (right) is open, so it becomes legal.
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b1101, 2'b00);
        run(0, pack(2'b01, 1'b1, 1'b0, 23'd132496));

        // Flee: cur_dir right excludes left; right is farthest.
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b0000, 2'b01);
        run(1, pack(2'b01, 1'b1, 1'b0, 23'd132496));
        // Fully walled: dir and best_dis2 hold.
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b1111, 2'b01);
        run(1, pack(2'b01, 1'b0, 1'b1, 23'd132496));

        // Extra start pulses while busy are ignored.
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b0000, 2'b00);
        exp_q0.push_back(pack(2'b00, 1'b1, 1'b0, 23'd121104));
        base = done_cnt0;
        pulse_start(0);
        b0.wall_mask = 4'b1111;
        first = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge Clk); #1;
            b0.start = (n == 3 || n == 8);
            if (b0.done && first == 0) first = n;
        end
        b0.start = 1'b0;
        check("busy_start_latency", 32'(first), 32'd13);
        check("busy_start_done_count", 32'(done_cnt0 - base), 32'd1);

        // Stop mid-search: no done, outputs unchanged.
        set_inputs(10'd456, 10'd253, 10'd100, 10'd253, 4'b0001, 2'b00);
        base = done_cnt0;
        pulse_start(0);
        for (int n = 1; n <= 25; n++) begin
            @(posedge Clk); #1;
            b0.stop = (n == 5);
            if (n == 6) check("stop_busy_low", 32'(b0.busy), 32'd0);
        end
        b0.stop = 1'b0;
        check("stop_done_count", 32'(done_cnt0 - base), 32'd0);
        check("stop_dir_held", 32'(b0.dir), 32'd0);
        check("stop_best_held", 32'(b0.best_dis2), 32'd121104);
        check("stop_dir_valid_held", 32'(b0.dir_valid), 32'd1);
        check("stop_fsm_idle", 32'(b0.fsm_state), 32'd0);

        // Asynchronous reset mid-search, then a clean search.
        base = done_cnt0;
        pulse_start(0);
        repeat (7) @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        check("async_reset_done_count", 32'(done_cnt0 - base), 32'd0);
        @(posedge Clk); #1;
        run(0, pack(2'b10, 1'b1, 1'b0, 23'd126800));

        repeat (3) @(posedge Clk);
        #1;
        check("chase_queue_drained", 32'(exp_q0.size()), 32'd0);
        check("flee_queue_drained", 32'(exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
